// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, select enum and address decode for dmem_responder
package dmem_pkg;

  localparam int DEFAULT_RAM_ADDR_BITS = 12;
  localparam int DEFAULT_FIFO_DEPTH    = 8;

  localparam logic [31:0] ADDR_STATUS   = 32'h0000_F000;
  localparam logic [31:0] ADDR_COIN_POP = 32'h0000_F001;
  localparam logic [31:0] ADDR_DISPLAY  = 32'h0000_F002;
  localparam logic [31:0] ADDR_TOTAL    = 32'h0000_F003;

  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_STATUS,
    SEL_POP,
    SEL_DISPLAY,
    SEL_TOTAL
  } dmem_sel_e;

  // RAM window takes priority so a very wide RAM can shadow the MMIO page.
  function automatic dmem_sel_e decode_addr(input logic [31:0] addr, input int ram_bits);
    if ((addr >> ram_bits) == 32'd0) return SEL_RAM;
    case (addr)
      ADDR_STATUS:   return SEL_STATUS;
      ADDR_COIN_POP: return SEL_POP;
      ADDR_DISPLAY:  return SEL_DISPLAY;
      ADDR_TOTAL:    return SEL_TOTAL;
      default:       return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// rtl/coin_fifo.sv - power-of-two coin value FIFO with occupancy count
module coin_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       slot_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = slot_mem[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register, cleared immediately by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok) slot_mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data RAM plus MMIO coin/display registers; COIN_FIFO_EN enables coin path
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_ADDR_BITS = DEFAULT_RAM_ADDR_BITS,
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  input  logic        coin_valid,
  input  logic [7:0]  coin_value,
  output logic        coin_ready,
  output logic [31:0] display_out
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;

  logic [31:0]              ram_mem [RAM_WORDS];
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  dmem_sel_e                sel;
  logic                     ram_we;
  logic [31:0]              display_q, display_d;
  logic [31:0]              q_dmem_q, q_dmem_d;
  logic [31:0]              status_word, pop_word, total_word;

  assign sel         = decode_addr(address_dmem, RAM_ADDR_BITS);
  assign ram_idx     = address_dmem[RAM_ADDR_BITS-1:0];
  assign ram_we      = wren && (sel == SEL_RAM);
  assign q_dmem      = q_dmem_q;
  assign display_out = display_q;

`ifdef COIN_FIFO_EN
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow_q, overflow_d;
  logic [31:0]      total_q, total_d;

  assign coin_ready = ~fifo_full;
  assign fifo_push  = coin_valid & coin_ready;
  assign fifo_pop   = (sel == SEL_POP) & ~wren & ~fifo_empty;

  coin_fifo #(.DEPTH(FIFO_DEPTH)) u_coin_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (coin_value),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow and running total; a fresh drop beats a same-cycle clear, a TOTAL write beats an add.
  always_comb begin
    overflow_d = overflow_q;
    total_d    = total_q;
    if ((sel == SEL_STATUS) && wren) overflow_d = 1'b0;
    if (coin_valid && fifo_full)     overflow_d = 1'b1;
    if (fifo_push)                   total_d    = total_q + {24'b0, coin_value};
    if ((sel == SEL_TOTAL) && wren)  total_d    = '0;
  end

  // Coin bookkeeping registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      overflow_q <= overflow_d;
      total_q    <= total_d;
    end
  end

  // Read views of the coin registers.
  always_comb begin
    status_word                              = '0;
    status_word[STATUS_EMPTY_BIT]            = fifo_empty;
    status_word[STATUS_FULL_BIT]             = fifo_full;
    status_word[STATUS_OVERFLOW_BIT]         = overflow_q;
    status_word[STATUS_COUNT_LSB +: 8]       = 8'(fifo_count);
    pop_word                                 = fifo_empty ? 32'd0 : {24'b0, fifo_head};
    total_word                               = total_q;
  end
`else
  logic unused_coin;

  assign coin_ready  = 1'b0;
  assign unused_coin = coin_valid ^ (^coin_value);
  assign status_word = '0;
  assign pop_word    = '0;
  assign total_word  = '0;
`endif

  // Register next-state and registered read data; a write cycle returns 0.
  always_comb begin
    display_d = display_q;
    if ((sel == SEL_DISPLAY) && wren) display_d = data;
    q_dmem_d = '0;
    if (!wren) begin
      case (sel)
        SEL_RAM:     q_dmem_d = ram_mem[ram_idx];
        SEL_STATUS:  q_dmem_d = status_word;
        SEL_POP:     q_dmem_d = pop_word;
        SEL_DISPLAY: q_dmem_d = display_q;
        SEL_TOTAL:   q_dmem_d = total_word;
        default:     q_dmem_d = '0;
      endcase
    end
  end

  // Display and read-data registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      display_q <= '0;
      q_dmem_q  <= '0;
    end else begin
      display_q <= display_d;
      q_dmem_q  <= q_dmem_d;
    end
  end

  // Data RAM; contents survive reset but no write commits while reset is held.
  always_ff @(posedge clock) begin
    if (reset && ram_we) ram_mem[ram_idx] <= data;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter RAM_ADDR_BITS, default 12, word-address width of data RAM (4096 words).
REQ-002 Parameter FIFO_DEPTH, default 8, coin FIFO entries (power of two, >=2).
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-005 address_dmem  in  32  word address from processor memory stage.
REQ-006 data  in  32  store data from processor.
REQ-007 wren  in  1  store enable; high = write, low = read.
REQ-008 q_dmem  out  32  load data returned to processor.
REQ-009 coin_valid  in  1  coin acceptor offers one coin event.
REQ-010 coin_value  in  8  coin value in cents, qualified by coin_valid.
REQ-011 coin_ready  out  1  responder accepts coin event this cycle.
REQ-012 display_out  out  32  contents of DISPLAY register, to front panel.

Function
REQ-013 Address decode SHALL be: address_dmem[31:RAM_ADDR_BITS]==0 -> RAM; 0x0000F000 STATUS; 0x0000F001 COIN_POP; 0x0000F002 DISPLAY; 0x0000F003 TOTAL; any other address reads 0 and ignores writes.
REQ-014 RAM write SHALL commit at the rising edge where wren=1 and address decodes to RAM.
REQ-015 Reads SHALL have one-cycle latency: q_dmem is registered from the address sampled at the previous rising edge with wren=0; q_dmem SHALL hold 0 after a write cycle.
REQ-016 Read of an address written in the immediately preceding cycle SHALL return the newly written value.
REQ-017 STATUS read SHALL return {16'b0, count[7:0], 5'b0, overflow, full, empty}.
REQ-018 STATUS write (any data) SHALL clear overflow; other STATUS bits read-only.
REQ-019 COIN_POP read SHALL return {24'b0, head value} and remove head in the same edge; when empty SHALL return 0 with no state change.
REQ-020 DISPLAY SHALL be read/write 32-bit; display_out reflects it continuously.
REQ-021 TOTAL SHALL add coin_value (zero-extended) on every accepted coin, wrapping modulo 2^32; a TOTAL write SHALL clear it to 0 (write wins over same-cycle add).
REQ-022 coin_ready SHALL equal ~full, combinational from registered count; a coin is accepted when coin_valid & coin_ready.
REQ-023 coin_valid while full SHALL drop the event, set overflow (sticky), and leave TOTAL unchanged.
REQ-024 Simultaneous accept and pop SHALL leave count unchanged; pop returns previous head; when empty, pop returns 0 and the coin is enqueued (count=1).
REQ-025 FIFO read/write pointers SHALL wrap at FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026 COIN_POP and TOTAL writes other than as specified SHALL be ignored.

Reset
REQ-027 Reset low SHALL clear q_dmem, DISPLAY, TOTAL, overflow, FIFO pointers and count to 0; coin_ready reads 1 during and after reset.
REQ-028 RAM contents SHALL NOT be cleared by reset; reset mid-pop or mid-write SHALL discard the in-flight operation.

Configuration
REQ-029 Macro COIN_FIFO_EN defined: coin FIFO, STATUS, COIN_POP, TOTAL behave as above.
REQ-030 COIN_FIFO_EN undefined: no FIFO or TOTAL logic; STATUS/COIN_POP/TOTAL read 0, writes ignored, coin_ready tied 0; RAM and DISPLAY unchanged.

Structure
REQ-031 Package dmem_pkg SHALL hold MMIO address constants, STATUS bit positions, default RAM_ADDR_BITS/FIFO_DEPTH.
REQ-032 FIFO SHALL be sub-module coin_fifo (push/pop/full/empty/count/head), instantiated only under COIN_FIFO_EN.

Verification
REQ-033 Write 0xDEADBEEF to 0x10, read 0x10 next cycle -> q_dmem=0xDEADBEEF one cycle after read issue.
REQ-034 Push coins 25,10,5; read TOTAL -> 40; pop x3 -> 25,10,5; fourth pop -> 0, STATUS empty=1.
REQ-035 Push 9 coins with FIFO_DEPTH=8 -> coin_ready=0 after 8th, overflow=1, count=8; STATUS write -> overflow=0.
REQ-036 FIFO full, coin_valid with COIN_POP read same cycle -> coin dropped, count=7, head returned.
REQ-037 Assert reset mid-sequence with count=3, DISPLAY=0x1234 -> count=0, DISPLAY=0, q_dmem=0, RAM word 0x10 retained.
REQ-038 Build without COIN_FIFO_EN -> coin_ready=0, STATUS read 0, DISPLAY write/read 0x55 -> 0x55.
